btb_assoc: RTL and testbench

Parametrised set-associative Branch Target Buffer for the RV32 fetch stage, successor to the direct-mapped BTB. It maps fetch PC to a predicted target, and adds a per-entry 2-bit saturating direction counter, a control-flow type tag, tree-PLRU replacement and a single-cycle flush. Lookup is combinational in IF; update arrives registered from EX/commit.

---
 rtl/btb_pkg.sv | 29 ++
 rtl/btb_plru.sv | 57 +++++
 rtl/btb_assoc.sv | 147 ++++++++++++++
 tb/tb_btb_assoc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared encodings and counter helpers for the set-associative BTB
// Contents: control-flow type encoding, 2-bit direction counter constants,
// saturating counter step functions.
package btb_pkg;

    typedef enum logic [1:0] {
        BT_COND = 2'b00,
        BT_JAL  = 2'b01,
        BT_JALR = 2'b10,
        BT_RET  = 2'b11
    } btb_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        return taken ? ctr_inc(c) : ctr_dec(c);
    endfunction

endpackage

// File: rtl/btb_plru.sv
// rtl/btb_plru.sv - combinational tree-PLRU next-state and victim for one set
// Ports: tree (current node bits, heap order, node 0 = root), touch_way (way
// being accessed), tree_next (bits after the touch), victim (way the current
// bits point at). A node bit of 1 means the victim lies in the right subtree.
module btb_plru #(
    parameter int WAYS = 2,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int NB = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [NB-1:0]    tree,
    input  logic [WAY_W-1:0] touch_way,
    output logic [NB-1:0]    tree_next,
    output logic [WAY_W-1:0] victim
);

    generate
        if (WAYS == 1) begin : g_direct
            logic unused_touch;
            assign unused_touch = ^touch_way;
            assign tree_next = tree;
            assign victim = '0;
        end else begin : g_tree
            localparam int LEVELS = $clog2(WAYS);

            // Walk the path of the touched way, pointing each node at the other half.
            always_comb begin : touch_walk
                int node;
                tree_next = tree;
                node = 0;
                for (int l = 0; l < LEVELS; l++) begin
                    for (int n = 0; n < NB; n++) begin
                        if (n == node) tree_next[n] = ~touch_way[LEVELS-1-l];
                    end
                    node = 2 * node + 1 + int'(touch_way[LEVELS-1-l]);
                end
            end

            // Victim search kept apart from the touch walk so the update path can
            // feed the victim back into touch_way without a combinational cycle.
            always_comb begin : victim_walk
                int  node;
                logic b;
                victim = '0;
                node = 0;
                for (int l = 0; l < LEVELS; l++) begin
                    b = 1'b0;
                    for (int n = 0; n < NB; n++) begin
                        if (n == node) b = tree[n];
                    end
                    victim[LEVELS-1-l] = b;
                    node = 2 * node + 1 + int'(b);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative branch target buffer with PLRU and flush
// Ports: clk, rst (sync, active-high), flush (drop all valid bits);
// lookup lu_valid/lu_pc -> hit, pred_taken, pred_target, pred_type (combinational);
// update upd_valid/upd_pc/upd_target/upd_taken/upd_type (written at next edge).
module btb_assoc
    import btb_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int WAYS    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        lu_valid,
    input  logic [31:0] lu_pc,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [1:0]  pred_type,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic [1:0]  upd_type
);

    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NB    = (WAYS > 1) ? WAYS - 1 : 1;

    logic             valid_q [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [31:0]      tgt_q   [SETS][WAYS];
    logic [1:0]       type_q  [SETS][WAYS];
    logic [1:0]       ctr_q   [SETS][WAYS];
    logic [NB-1:0]    plru_q  [SETS];

    logic             unused_lsbs;
    assign unused_lsbs = ^{lu_pc[1:0], upd_pc[1:0]};

    logic [IDX_W-1:0] lu_idx, upd_idx;
    logic [TAG_W-1:0] lu_tag, upd_tag;
    assign lu_idx  = lu_pc[IDX_W+1:2];
    assign lu_tag  = lu_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    logic             lu_hit, upd_hit, inv_found;
    logic [WAY_W-1:0] lu_way, upd_hit_way, inv_way, plru_victim, upd_way;
    logic [NB-1:0]    lu_tree_next, upd_tree_next;
    logic [WAY_W-1:0] unused_lu_victim;

    always_comb begin
        lu_hit = 1'b0;
        lu_way = '0;
        upd_hit = 1'b0;
        upd_hit_way = '0;
        inv_found = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lu_idx][w] && tag_q[lu_idx][w] == lu_tag) begin
                lu_hit = 1'b1;
                lu_way = WAY_W'(w);
            end
            if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
                upd_hit = 1'b1;
                upd_hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][w]) begin
                inv_found = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign upd_way = upd_hit ? upd_hit_way : (inv_found ? inv_way : plru_victim);

    btb_plru #(.WAYS(WAYS)) u_plru_lu (
        .tree      (plru_q[lu_idx]),
        .touch_way (lu_way),
        .tree_next (lu_tree_next),
        .victim    (unused_lu_victim)
    );

    btb_plru #(.WAYS(WAYS)) u_plru_upd (
        .tree      (plru_q[upd_idx]),
        .touch_way (upd_way),
        .tree_next (upd_tree_next),
        .victim    (plru_victim)
    );

    assign hit         = lu_hit;
    assign pred_target = lu_hit ? tgt_q[lu_idx][lu_way] : '0;
    assign pred_type   = lu_hit ? type_q[lu_idx][lu_way] : 2'b00;
    assign pred_taken  = lu_hit && (type_q[lu_idx][lu_way] != BT_COND || ctr_q[lu_idx][lu_way][1]);

    logic upd_write;
    assign upd_write = upd_valid && (upd_hit || upd_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    tgt_q[s][w]   <= '0;
                    type_q[s][w]  <= 2'b00;
                    ctr_q[s][w]   <= CTR_SNT;
                end
                plru_q[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else begin
            // The update owns a set's PLRU when both paths touch it this cycle.
            if (lu_valid && lu_hit && !(upd_write && upd_idx == lu_idx)) begin
                plru_q[lu_idx] <= lu_tree_next;
            end
            if (upd_write) begin
                plru_q[upd_idx] <= upd_tree_next;
                if (upd_hit) begin
                    ctr_q[upd_idx][upd_way] <= ctr_step(ctr_q[upd_idx][upd_way], upd_taken);
                    if (upd_taken) begin
                        tgt_q[upd_idx][upd_way]  <= upd_target;
                        type_q[upd_idx][upd_way] <= upd_type;
                    end
                end else begin
                    valid_q[upd_idx][upd_way] <= 1'b1;
                    tag_q[upd_idx][upd_way]   <= upd_tag;
                    tgt_q[upd_idx][upd_way]   <= upd_target;
                    type_q[upd_idx][upd_way]  <= upd_type;
                    ctr_q[upd_idx][upd_way]   <= CTR_WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - directed and randomized self-checking bench for btb_assoc
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        rst, flush, lu_valid, upd_valid, upd_taken;
    logic [31:0] lu_pc, upd_pc, upd_target;
    logic [1:0]  upd_type;
    logic        hit, pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pred_type;

    always #5 clk = ~clk;

    btb_assoc #(.ENTRIES(64), .WAYS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .lu_valid    (lu_valid),
        .lu_pc       (lu_pc),
        .hit         (hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pred_type   (pred_type),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_type    (upd_type)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference model: 32 sets x 2 ways. With two ways the PLRU tree is true LRU,
    // so each set just remembers which way should be replaced next.
    bit          m_valid [32][2];
    int unsigned m_tag   [32][2];
    logic [31:0] m_tgt   [32][2];
    int          m_type  [32][2];
    int          m_ctr   [32][2];
    int          m_lru   [32];

    function automatic int m_set(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd31);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return pc >> 7;
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        int s;
        s = m_set(pc);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == m_tagof(pc)) return w;
        return -1;
    endfunction

    task automatic m_edge();
        int ls, lw, us, uw, w;
        bit utouch;
        if (rst) begin
            for (int s = 0; s < 32; s++) begin
                for (int k = 0; k < 2; k++) begin
                    m_valid[s][k] = 0; m_tag[s][k] = 0; m_tgt[s][k] = 0;
                    m_type[s][k] = 0; m_ctr[s][k] = 0;
                end
                m_lru[s] = 0;
            end
        end else if (flush) begin
            for (int s = 0; s < 32; s++)
                for (int k = 0; k < 2; k++) m_valid[s][k] = 0;
        end else begin
            ls = m_set(lu_pc);  lw = m_find(lu_pc);
            us = m_set(upd_pc); uw = m_find(upd_pc);
            utouch = 0;
            if (upd_valid) begin
                if (uw >= 0) begin
                    if (upd_taken) begin
                        if (m_ctr[us][uw] < 3) m_ctr[us][uw]++;
                        m_tgt[us][uw] = upd_target;
                        m_type[us][uw] = int'(upd_type);
                    end else if (m_ctr[us][uw] > 0) begin
                        m_ctr[us][uw]--;
                    end
                    m_lru[us] = 1 - uw;
                    utouch = 1;
                end else if (upd_taken) begin
                    w = !m_valid[us][0] ? 0 : (!m_valid[us][1] ? 1 : m_lru[us]);
                    m_valid[us][w] = 1;
                    m_tag[us][w] = m_tagof(upd_pc);
                    m_tgt[us][w] = upd_target;
                    m_type[us][w] = int'(upd_type);
                    m_ctr[us][w] = 2;
                    m_lru[us] = 1 - w;
                    utouch = 1;
                end
            end
            if (lu_valid && lw >= 0 && !(utouch && us == ls)) m_lru[ls] = 1 - lw;
        end
    endtask

    task automatic check_model();
        int s, w;
        bit eh, et;
        s = m_set(lu_pc);
        w = m_find(lu_pc);
        eh = (w >= 0);
        et = eh && (m_type[s][w] != 0 || m_ctr[s][w] >= 2);
        check("rnd_hit", 32'(hit), 32'(eh));
        check("rnd_taken", 32'(pred_taken), 32'(et));
        check("rnd_target", pred_target, eh ? m_tgt[s][w] : 32'h0);
        check("rnd_type", 32'(pred_type), eh ? 32'(m_type[s][w]) : 32'h0);
    endtask

    task automatic peek(input string tag, input logic [31:0] pc, input bit eh, input bit et,
                        input logic [31:0] etgt, input logic [1:0] ety);
        lu_pc = pc;
        lu_valid = 1'b0;
        #1;
        check({tag, "_hit"}, 32'(hit), 32'(eh));
        check({tag, "_taken"}, 32'(pred_taken), 32'(et));
        check({tag, "_target"}, pred_target, etgt);
        check({tag, "_type"}, 32'(pred_type), 32'(ety));
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input bit taken,
                          input logic [1:0] ty);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = taken; upd_type = ty;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] t, s, l;
        t = 32'($urandom_range(0, 5));
        s = 32'($urandom_range(0, 3));
        l = 32'($urandom_range(0, 3));
        return (t << 7) | (s << 2) | l;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; lu_valid = 1'b0; lu_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_type = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        peek("rst_0", 32'h0, 0, 0, 32'h0, 2'b00);
        peek("rst_8", 32'h8000_0000, 0, 0, 32'h0, 2'b00);

        do_upd(32'h100, 32'h200, 1, 2'b00);
        peek("alloc", 32'h100, 1, 1, 32'h200, 2'b00);
        peek("alloc_lsb", 32'h102, 1, 1, 32'h200, 2'b00);
        do_upd(32'h100, 32'h999, 0, 2'b00);
        do_upd(32'h100, 32'h999, 0, 2'b00);
        peek("ctr_floor", 32'h100, 1, 0, 32'h200, 2'b00);

        do_upd(32'h180, 32'h280, 1, 2'b00);
        lu_pc = 32'h100; lu_valid = 1'b1;
        @(posedge clk);
        #1 lu_valid = 1'b0;
        do_upd(32'h200, 32'h300, 1, 2'b00);
        peek("evicted", 32'h180, 0, 0, 32'h0, 2'b00);
        peek("kept", 32'h100, 1, 0, 32'h200, 2'b00);
        peek("newer", 32'h200, 1, 1, 32'h300, 2'b00);

        do_upd(32'h300, 32'h400, 0, 2'b00);
        peek("nt_miss", 32'h300, 0, 0, 32'h0, 2'b00);

        lu_pc = 32'h404; lu_valid = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h404; upd_target = 32'h500; upd_taken = 1'b1; upd_type = 2'b10;
        #1 check("simul_old", 32'(hit), 32'h0);
        @(posedge clk);
        #1 upd_valid = 1'b0; lu_valid = 1'b0;
        peek("simul_new", 32'h404, 1, 1, 32'h500, 2'b10);

        flush = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h808; upd_target = 32'h123; upd_taken = 1'b1; upd_type = 2'b00;
        @(posedge clk);
        #1 flush = 1'b0; upd_valid = 1'b0;
        peek("flush_a", 32'h404, 0, 0, 32'h0, 2'b00);
        peek("flush_b", 32'h200, 0, 0, 32'h0, 2'b00);
        peek("flush_upd", 32'h808, 0, 0, 32'h0, 2'b00);

        do_upd(32'h70C, 32'h900, 1, 2'b01);
        do_upd(32'h70C, 32'h0, 0, 2'b01);
        do_upd(32'h70C, 32'h0, 0, 2'b01);
        peek("jal_ctr0", 32'h70C, 1, 1, 32'h900, 2'b01);

        rst = 1'b1;
        @(posedge clk);
        m_edge();
        #1 rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            flush      = ($urandom_range(0, 59) == 0);
            lu_valid   = 1'($urandom_range(0, 1));
            lu_pc      = rpc();
            upd_valid  = ($urandom_range(0, 3) != 0);
            upd_pc     = ($urandom_range(0, 3) == 0) ? lu_pc : rpc();
            upd_target = $urandom;
            upd_taken  = ($urandom_range(0, 2) != 0);
            upd_type   = 2'($urandom_range(0, 3));
            #1 check_model();
            @(posedge clk);
            m_edge();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
